// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set-2 key event decoder.
// Turns the raw byte stream (make codes, F0 break prefix, E0 extended
// prefix) into per-key held levels and single-cycle press pulses, with
// auto-repeat on left/right/down.
module ps2_key_event_decoder #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [8:0] key_pulse,
  output logic [8:0] key_held,
  output logic [7:0] last_code
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2,
    S_EBRK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    pulse_q, pulse_d;
  logic [8:0]    held_q, held_d;
  logic [7:0]    last_q, last_d;
  logic [1:0]    rep_sel_q, rep_sel_d;
  logic          rep_active_q, rep_active_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          is_make, is_brk, is_ext;
  logic [4:0]    map_r;
  logic          map_hit;
  logic [3:0]    map_idx;

  // Key map: returns {hit, key index}; unmapped codes give hit=0.
  function automatic logic [4:0] map_key(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    if (!ext) begin
      case (code)
        8'h1C: r = {1'b1, 4'd0};
        8'h23: r = {1'b1, 4'd1};
        8'h1B: r = {1'b1, 4'd2};
        8'h1D: r = {1'b1, 4'd3};
        8'h5A: r = {1'b1, 4'd4};
        8'h66: r = {1'b1, 4'd5};
        8'h16: r = {1'b1, 4'd6};
        8'h1E: r = {1'b1, 4'd7};
        8'h26: r = {1'b1, 4'd8};
        default: r = 5'd0;
      endcase
    end else begin
      case (code)
        8'h6B: r = {1'b1, 4'd0};
        8'h74: r = {1'b1, 4'd1};
        8'h72: r = {1'b1, 4'd2};
        8'h75: r = {1'b1, 4'd3};
        8'h5A: r = {1'b1, 4'd4};
        default: r = 5'd0;
      endcase
    end
    return r;
  endfunction

  // Parser next state; flags whether this strobe completes a make or break.
  always_comb begin
    state_d = state_q;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (ps2_key_pressed) begin
      case (state_q)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0)      state_d = S_EXT;
          else if (ps2_key_data == 8'hF0) state_d = S_BRK;
          else                            is_make = 1'b1;
        end
        S_EXT: begin
          if (ps2_key_data == 8'hF0)      state_d = S_EBRK;
          else if (ps2_key_data == 8'hE0) state_d = S_EXT;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          is_brk  = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          is_brk  = 1'b1;
          is_ext  = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign map_r   = map_key(is_ext, ps2_key_data);
  assign map_hit = map_r[4];
  assign map_idx = map_r[3:0];

  // Key levels, press pulses and auto-repeat; a new repeatable press
  // overrides a coinciding repeat reload, but the repeat pulse still fires.
  always_comb begin
    pulse_d      = 9'd0;
    held_d       = held_q;
    last_d       = last_q;
    rep_sel_d    = rep_sel_q;
    rep_active_d = rep_active_q;
    cnt_d        = cnt_q;

    if (rep_active_q) begin
      if (cnt_q == '0) begin
        pulse_d[rep_sel_q] = 1'b1;
        cnt_d              = CW'(REPEAT_RATE - 1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (is_make && map_hit) begin
      last_d = ps2_key_data;
      if (!held_q[map_idx]) begin
        held_d[map_idx]  = 1'b1;
        pulse_d[map_idx] = 1'b1;
        if (map_idx < 4'd3) begin
          rep_sel_d    = map_idx[1:0];
          rep_active_d = 1'b1;
          cnt_d        = CW'(REPEAT_DELAY - 1);
        end
      end
    end

    if (is_brk && map_hit) begin
      held_d[map_idx] = 1'b0;
      if (rep_active_q && (map_idx < 4'd3) && (map_idx[1:0] == rep_sel_q))
        rep_active_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      pulse_q      <= 9'd0;
      held_q       <= 9'd0;
      last_q       <= 8'h00;
      rep_sel_q    <= 2'd0;
      rep_active_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pulse_q      <= pulse_d;
      held_q       <= held_d;
      last_q       <= last_d;
      rep_sel_q    <= rep_sel_d;
      rep_active_q <= rep_active_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_pulse = pulse_q;
  assign key_held  = held_q;
  assign last_code = last_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Testbench for ps2_key_event_decoder with REPEAT_DELAY=8, REPEAT_RATE=4.
module tb_ps2_key_event_decoder;

  logic       clk;
  logic       rstn;
  logic [7:0] data;
  logic       pressed;
  logic [8:0] key_pulse;
  logic [8:0] key_held;
  logic [7:0] last_code;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    logic [8:0] p;
    logic [8:0] h;
    logic [7:0] lc;
  } vec_t;

  vec_t vecs[40];
  int   nv = 0;

  ps2_key_event_decoder #(.REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .CLOCK_50       (clk),
    .Resetn         (rstn),
    .ps2_key_data   (data),
    .ps2_key_pressed(pressed),
    .key_pulse      (key_pulse),
    .key_held       (key_held),
    .last_code      (last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One strobe; returns on the negedge after the edge that consumed it.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data    = b;
    pressed = 1'b1;
    @(negedge clk);
    pressed = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic tick_pulse(input string name, input logic [8:0] exp);
    @(negedge clk);
    chk(name, {23'd0, key_pulse}, {23'd0, exp});
  endtask

  task automatic add(input logic [7:0] b, input logic [8:0] p, input logic [8:0] h,
                     input logic [7:0] lc);
    vecs[nv].b  = b;
    vecs[nv].p  = p;
    vecs[nv].h  = h;
    vecs[nv].lc = lc;
    nv++;
  endtask

  initial begin
    rstn    = 1'b0;
    data    = 8'h00;
    pressed = 1'b0;

    add(8'h5A, 9'h010, 9'h010, 8'h5A);
    add(8'hF0, 9'h000, 9'h010, 8'h5A);
    add(8'h5A, 9'h000, 9'h000, 8'h5A);
    add(8'hE0, 9'h000, 9'h000, 8'h5A);
    add(8'h75, 9'h008, 9'h008, 8'h75);
    add(8'hE0, 9'h000, 9'h008, 8'h75);
    add(8'h75, 9'h000, 9'h008, 8'h75);
    add(8'hE0, 9'h000, 9'h008, 8'h75);
    add(8'hF0, 9'h000, 9'h008, 8'h75);
    add(8'h75, 9'h000, 9'h000, 8'h75);
    add(8'h6B, 9'h000, 9'h000, 8'h75);
    add(8'hAA, 9'h000, 9'h000, 8'h75);
    add(8'hFA, 9'h000, 9'h000, 8'h75);
    add(8'hE1, 9'h000, 9'h000, 8'h75);
    add(8'h45, 9'h000, 9'h000, 8'h75);
    add(8'hF0, 9'h000, 9'h000, 8'h75);
    add(8'h45, 9'h000, 9'h000, 8'h75);
    add(8'h16, 9'h040, 9'h040, 8'h16);
    add(8'h1E, 9'h080, 9'h0C0, 8'h1E);
    add(8'hF0, 9'h000, 9'h0C0, 8'h1E);
    add(8'h16, 9'h000, 9'h080, 8'h1E);
    add(8'h66, 9'h020, 9'h0A0, 8'h66);
    add(8'hE0, 9'h000, 9'h0A0, 8'h66);
    add(8'h66, 9'h000, 9'h0A0, 8'h66);
    add(8'hE0, 9'h000, 9'h0A0, 8'h66);
    add(8'h5A, 9'h010, 9'h0B0, 8'h5A);
    add(8'hE0, 9'h000, 9'h0B0, 8'h5A);
    add(8'hF0, 9'h000, 9'h0B0, 8'h5A);
    add(8'h5A, 9'h000, 9'h0A0, 8'h5A);
    add(8'h26, 9'h100, 9'h1A0, 8'h26);
    add(8'hF0, 9'h000, 9'h1A0, 8'h26);
    add(8'h1E, 9'h000, 9'h120, 8'h26);
    add(8'hF0, 9'h000, 9'h120, 8'h26);
    add(8'h66, 9'h000, 9'h100, 8'h26);
    add(8'hF0, 9'h000, 9'h100, 8'h26);
    add(8'h26, 9'h000, 9'h000, 8'h26);

    // Reset mid-sequence after E0 discards the prefix.
    do_reset();
    send(8'h16);
    chk("pre_reset_held", {23'd0, key_held}, 32'h040);
    send(8'hE0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pulse", {23'd0, key_pulse}, 32'h0);
    chk("rst_held", {23'd0, key_held}, 32'h0);
    chk("rst_last", {24'd0, last_code}, 32'h0);
    rstn = 1'b1;
    send(8'h1D);
    chk("post_rst_pulse", {23'd0, key_pulse}, 32'h008);
    chk("post_rst_held", {23'd0, key_held}, 32'h008);
    chk("post_rst_last", {24'd0, last_code}, 32'h1D);
    tick_pulse("post_rst_pulse_1cyc", 9'h000);

    // Table of single-byte steps from a clean reset.
    do_reset();
    for (int i = 0; i < nv; i++) begin
      send(vecs[i].b);
      chk($sformatf("vec%0d_pulse", i), {23'd0, key_pulse}, {23'd0, vecs[i].p});
      chk($sformatf("vec%0d_held", i), {23'd0, key_held}, {23'd0, vecs[i].h});
      chk($sformatf("vec%0d_last", i), {24'd0, last_code}, {24'd0, vecs[i].lc});
    end

    // Extended left: typematic repeat gives no pulse, extended break clears.
    do_reset();
    send(8'hE0);
    send(8'h6B);
    chk("ext_left_pulse", {23'd0, key_pulse}, 32'h001);
    chk("ext_left_held", {23'd0, key_held}, 32'h001);
    send(8'hE0);
    send(8'h6B);
    chk("ext_typematic_pulse", {23'd0, key_pulse}, 32'h000);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("ext_break_held", {23'd0, key_held}, 32'h000);
    chk("ext_break_pulse", {23'd0, key_pulse}, 32'h000);

    // Auto-repeat timing on left: T, T+8, T+12, T+16; none after break.
    do_reset();
    send(8'h1C);
    chk("rep_T0", {23'd0, key_pulse}, 32'h001);
    for (int n = 1; n <= 17; n++)
      tick_pulse($sformatf("rep_T%0d", n), (n == 8 || n == 12 || n == 16) ? 9'h001 : 9'h000);
    send(8'hF0);
    send(8'h1C);
    chk("rep_brk_held", {23'd0, key_held}, 32'h000);
    for (int n = 0; n < 20; n++)
      tick_pulse($sformatf("rep_after_brk%0d", n), 9'h000);

    // Handover: right takes over repeat; break of left does not stop it.
    do_reset();
    send(8'h1C);
    chk("ho_left", {23'd0, key_pulse}, 32'h001);
    for (int n = 1; n <= 3; n++)
      tick_pulse($sformatf("ho_pre%0d", n), 9'h000);
    send(8'h23);
    chk("ho_right_T0", {23'd0, key_pulse}, 32'h002);
    for (int m = 1; m <= 13; m++)
      tick_pulse($sformatf("ho_T%0d", m), (m == 8 || m == 12) ? 9'h002 : 9'h000);
    send(8'hF0);
    send(8'h1C);
    chk("ho_brk_left_pulse", {23'd0, key_pulse}, 32'h000);
    chk("ho_brk_left_held", {23'd0, key_held}, 32'h002);
    for (int m = 18; m <= 24; m++)
      tick_pulse($sformatf("ho_T%0d", m), (m == 20 || m == 24) ? 9'h002 : 9'h000);

    // New repeatable press coinciding with a repeat expiry: both pulse.
    do_reset();
    send(8'h1C);
    chk("co_T0", {23'd0, key_pulse}, 32'h001);
    for (int n = 1; n <= 6; n++)
      tick_pulse($sformatf("co_T%0d", n), 9'h000);
    send(8'h1B);
    chk("co_T8_both", {23'd0, key_pulse}, 32'h005);
    for (int n = 9; n <= 17; n++)
      tick_pulse($sformatf("co_T%0d", n), (n == 16) ? 9'h004 : 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
